// File: rtl/pu_check_sequencer_if.sv
// Bus bundle around the protection-unit check sequencer: upstream AR/AW,
// downstream AR/AW, PolicyCheck request/response and deny reporting.
interface pu_check_sequencer_if #(
   parameter int ID_WIDTH   = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [ID_WIDTH-1:0]   S_ARID;
   logic [ADDR_WIDTH-1:0] S_ARADDR;
   logic [7:0]            S_ARLEN;
   logic [2:0]            S_ARSIZE;
   logic                  S_ARVALID;
   logic                  S_ARREADY;

   logic [ID_WIDTH-1:0]   S_AWID;
   logic [ADDR_WIDTH-1:0] S_AWADDR;
   logic [7:0]            S_AWLEN;
   logic [2:0]            S_AWSIZE;
   logic                  S_AWVALID;
   logic                  S_AWREADY;

   logic [ID_WIDTH-1:0]   M_ARID;
   logic [ADDR_WIDTH-1:0] M_ARADDR;
   logic [7:0]            M_ARLEN;
   logic [2:0]            M_ARSIZE;
   logic                  M_ARVALID;
   logic                  M_ARREADY;

   logic [ID_WIDTH-1:0]   M_AWID;
   logic [ADDR_WIDTH-1:0] M_AWADDR;
   logic [7:0]            M_AWLEN;
   logic [2:0]            M_AWSIZE;
   logic                  M_AWVALID;
   logic                  M_AWREADY;

   logic [ID_WIDTH-1:0]   CHK_ID;
   logic [ADDR_WIDTH-1:0] CHK_ADDR;
   logic [7:0]            CHK_LEN;
   logic [2:0]            CHK_SIZE;
   logic                  CHK_READ_WRITE;
   logic                  CHK_GRANTED;

   logic                  DENY_VALID;
   logic                  DENY_RW;
   logic [ID_WIDTH-1:0]   DENY_ID;
   logic [CNT_WIDTH-1:0]  DENY_COUNT;

   // Environment side: upstream master, downstream slave and PolicyCheck.
   modport master (
      output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARVALID,
      input  S_ARREADY,
      output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWVALID,
      input  S_AWREADY,
      input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARVALID,
      output M_ARREADY,
      input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWVALID,
      output M_AWREADY,
      input  CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE,
      output CHK_GRANTED,
      input  DENY_VALID, DENY_RW, DENY_ID, DENY_COUNT
   );

   // Sequencer side.
   modport slave (
      input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARVALID,
      output S_ARREADY,
      input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWVALID,
      output S_AWREADY,
      output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARVALID,
      input  M_ARREADY,
      output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWVALID,
      input  M_AWREADY,
      output CHK_ID, CHK_ADDR, CHK_LEN, CHK_SIZE, CHK_READ_WRITE,
      input  CHK_GRANTED,
      output DENY_VALID, DENY_RW, DENY_ID, DENY_COUNT
   );
endinterface

// File: rtl/pu_check_sequencer.sv
// Protection-unit front end: round-robin AR/AW arbitration into one shared
// PolicyCheck, then forward granted requests or report and count denials.
module pu_check_sequencer #(
   parameter int ID_WIDTH   = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic               ACLK,
   input logic               ARESET,
   pu_check_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CHECK, FWD, DENY} state_t;

   state_t                state, state_nxt;
   logic                  last_rw;
   logic [ID_WIDTH-1:0]   hold_id;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [7:0]            hold_len;
   logic [2:0]            hold_size;
   logic                  hold_rw;
   logic [CNT_WIDTH-1:0]  deny_count;
   logic                  sel_ar;
   logic                  sel_aw;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt      = state;
      sel_ar         = 1'b0;
      sel_aw         = 1'b0;
      bus.M_ARVALID  = 1'b0;
      bus.M_AWVALID  = 1'b0;
      bus.DENY_VALID = 1'b0;
      case (state)
         IDLE: begin
            // Reset gating keeps READY low while ARESET is held.
            if (!ARESET) begin
               sel_ar = bus.S_ARVALID && (!bus.S_AWVALID || last_rw);
               sel_aw = bus.S_AWVALID && (!bus.S_ARVALID || !last_rw);
            end
            if (sel_ar || sel_aw) state_nxt = CHECK;
         end
         CHECK: state_nxt = bus.CHK_GRANTED ? FWD : DENY;
         FWD: begin
            bus.M_ARVALID = !hold_rw;
            bus.M_AWVALID = hold_rw;
            if (hold_rw ? bus.M_AWREADY : bus.M_ARREADY) state_nxt = IDLE;
         end
         DENY: begin
            bus.DENY_VALID = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the holding register is reset too, so CHK_* and M_* payloads read zero after reset.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         last_rw    <= 1'b1;
         hold_id    <= '0;
         hold_addr  <= '0;
         hold_len   <= '0;
         hold_size  <= '0;
         hold_rw    <= 1'b0;
         deny_count <= '0;
      end else begin
         if (sel_ar) begin
            hold_id   <= bus.S_ARID;
            hold_addr <= bus.S_ARADDR;
            hold_len  <= bus.S_ARLEN;
            hold_size <= bus.S_ARSIZE;
            hold_rw   <= 1'b0;
            last_rw   <= 1'b0;
         end else if (sel_aw) begin
            hold_id   <= bus.S_AWID;
            hold_addr <= bus.S_AWADDR;
            hold_len  <= bus.S_AWLEN;
            hold_size <= bus.S_AWSIZE;
            hold_rw   <= 1'b1;
            last_rw   <= 1'b1;
         end
         if (state == DENY && deny_count != '1) deny_count <= deny_count + CNT_WIDTH'(1);
      end
   end

   assign bus.S_ARREADY      = sel_ar;
   assign bus.S_AWREADY      = sel_aw;

   assign bus.CHK_ID         = hold_id;
   assign bus.CHK_ADDR       = hold_addr;
   assign bus.CHK_LEN        = hold_len;
   assign bus.CHK_SIZE       = hold_size;
   assign bus.CHK_READ_WRITE = hold_rw;

   assign bus.M_ARID         = hold_id;
   assign bus.M_ARADDR       = hold_addr;
   assign bus.M_ARLEN        = hold_len;
   assign bus.M_ARSIZE       = hold_size;
   assign bus.M_AWID         = hold_id;
   assign bus.M_AWADDR       = hold_addr;
   assign bus.M_AWLEN        = hold_len;
   assign bus.M_AWSIZE       = hold_size;

   assign bus.DENY_RW        = (state == DENY) && hold_rw;
   assign bus.DENY_ID        = (state == DENY) ? hold_id : '0;
   assign bus.DENY_COUNT     = deny_count;

endmodule
